npu_dot_issuer: RTL and testbench

Initiator side of the NPU dual-MAC datapath (Gowin MULTADDALU, dout = a0*b0 + a1*b1, registered inputs and registered output). It accepts a job length and a valid/ready stream of operand quads, and issues each quad to the MAC. It tracks in-flight results with a tag pipeline, accumulates the returned partial sums, and presents one dot-product result per job on a valid/ready output port.

---
 rtl/npu_mac_pkg.sv | 23 ++
 rtl/npu_tag_pipe.sv | 28 ++
 rtl/npu_dot_issuer.sv | 148 ++++++++++++++
 tb/tb_npu_dot_issuer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_mac_pkg.sv
// Shared types and constants for the NPU dual-MAC datapath.
// The constants describe the default Gowin MULTADDALU configuration.
package npu_mac_pkg;

   localparam int unsigned MAC_DATA_W  = 18;
   localparam int unsigned MAC_DOUT_W  = 37;
   localparam int unsigned MAC_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_HOLD
   } issuer_state_t;

   typedef struct packed {
      logic signed [MAC_DATA_W-1:0] a0;
      logic signed [MAC_DATA_W-1:0] b0;
      logic signed [MAC_DATA_W-1:0] a1;
      logic signed [MAC_DATA_W-1:0] b1;
   } quad_t;

endpackage

// File: rtl/npu_tag_pipe.sv
// Valid-bit shift register tracking which MAC results belong to issued quads.
// all_clear reports that every stage ahead of the output stage is empty.
module npu_tag_pipe
   import npu_mac_pkg::*;
#(
   parameter int unsigned DEPTH = MAC_LAT_DEF + 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_valid,
   output logic out_valid,
   output logic all_clear
);

   logic [DEPTH-1:0] tag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag <= '0;
      end else begin
         tag <= {tag[DEPTH-2:0], in_valid};
      end
   end

   assign out_valid = tag[DEPTH-1];
   assign all_clear = ~|tag[DEPTH-2:0];

endmodule

// File: rtl/npu_dot_issuer.sv
// Issues operand quads to a dual-MAC, accumulates the tagged partial sums
// and presents one dot-product result per job on a valid/ready port.
module npu_dot_issuer
   import npu_mac_pkg::*;
#(
   parameter int unsigned DATA_W    = MAC_DATA_W,
   parameter int unsigned MAC_OUT_W = MAC_DOUT_W,
   parameter int unsigned ACC_W     = 48,
   parameter int unsigned MAC_LAT   = MAC_LAT_DEF,
   parameter int unsigned LEN_W     = 10
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic        [LEN_W-1:0]     cfg_len,
   output logic                        busy,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic signed [DATA_W-1:0]    op_a0,
   input  logic signed [DATA_W-1:0]    op_b0,
   input  logic signed [DATA_W-1:0]    op_a1,
   input  logic signed [DATA_W-1:0]    op_b1,
   output logic                        mac_ce,
   output logic                        mac_reset,
   output logic signed [DATA_W-1:0]    mac_a0,
   output logic signed [DATA_W-1:0]    mac_b0,
   output logic signed [DATA_W-1:0]    mac_a1,
   output logic signed [DATA_W-1:0]    mac_b1,
   input  logic signed [MAC_OUT_W-1:0] mac_dout,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic signed [ACC_W-1:0]     res_data,
   output logic                        res_ovf
);

   issuer_state_t           state, state_next;
   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        issue_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] dout_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    ovf;
   logic                    step_ovf;
   logic                    accept;
   logic                    tag_out;
   logic                    tag_clear;

   assign accept = op_valid && op_ready;

   npu_tag_pipe #(
      .DEPTH(MAC_LAT + 1)
   ) u_tag_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (accept),
      .out_valid(tag_out),
      .all_clear(tag_clear)
   );

   // Signed size cast sign-extends and also covers ACC_W == MAC_OUT_W.
   assign dout_ext = ACC_W'(mac_dout);
   assign acc_sum  = acc + dout_ext;
   assign step_ovf = (acc[ACC_W-1] == dout_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc[ACC_W-1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b1;
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      mac_ce     = 1'b0;
      mac_reset  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            busy      = 1'b0;
            mac_reset = 1'b1;
            if (start) begin
               state_next = (cfg_len != '0) ? ST_RUN : ST_HOLD;
            end
         end
         ST_RUN: begin
            op_ready = 1'b1;
            mac_ce   = 1'b1;
            if (accept && (issue_cnt + LEN_W'(1) == len_q)) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            mac_ce = 1'b1;
            if (tag_out && tag_clear) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q     <= '0;
         issue_cnt <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         mac_a0    <= '0;
         mac_b0    <= '0;
         mac_a1    <= '0;
         mac_b1    <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            len_q     <= cfg_len;
            issue_cnt <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
         end
         if (accept) begin
            mac_a0    <= op_a0;
            mac_b0    <= op_b0;
            mac_a1    <= op_a1;
            mac_b1    <= op_b1;
            issue_cnt <= issue_cnt + LEN_W'(1);
         end
         if (tag_out) begin
            acc <= acc_sum;
            if (step_ovf) begin
               ovf <= 1'b1;
            end
         end
      end
   end

   assign res_data = acc;
   assign res_ovf  = ovf;

endmodule

// File: tb/tb_npu_dot_issuer.sv
// Bench for npu_dot_issuer: two instances (ACC_W 48 and 38) share stimulus,
// each driving its own behavioural dual-MAC with two register stages.
module tb_npu_dot_issuer;
   import npu_mac_pkg::*;

   localparam int DW  = MAC_DATA_W;
   localparam int OW  = MAC_DOUT_W;
   localparam int LW  = 10;
   localparam int AWA = 48;
   localparam int AWB = 38;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic [LW-1:0]        cfg_len = '0;
   logic                 op_valid = 1'b0;
   logic                 res_ready = 1'b0;
   logic signed [DW-1:0] op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;

   logic                 busy[2], op_ready[2], mac_ce[2], mac_reset[2];
   logic                 res_valid[2], res_ovf[2];
   logic signed [DW-1:0] ma0[2], mb0[2], ma1[2], mb1[2];
   logic signed [OW-1:0] dout[2];
   logic signed [DW-1:0] mr[2][4];
   logic signed [AWA-1:0] rd_a;
   logic signed [AWB-1:0] rd_b;

   int n_chk = 0;
   int n_fail = 0;
   int rdy_cnt = 0;
   int ce_cnt = 0;

   npu_dot_issuer #(.DATA_W(DW), .MAC_OUT_W(OW), .ACC_W(AWA), .MAC_LAT(2), .LEN_W(LW)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len), .busy(busy[0]),
      .op_valid(op_valid), .op_ready(op_ready[0]),
      .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
      .mac_ce(mac_ce[0]), .mac_reset(mac_reset[0]),
      .mac_a0(ma0[0]), .mac_b0(mb0[0]), .mac_a1(ma1[0]), .mac_b1(mb1[0]),
      .mac_dout(dout[0]), .res_valid(res_valid[0]), .res_ready(res_ready),
      .res_data(rd_a), .res_ovf(res_ovf[0]));

   npu_dot_issuer #(.DATA_W(DW), .MAC_OUT_W(OW), .ACC_W(AWB), .MAC_LAT(2), .LEN_W(LW)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start), .cfg_len(cfg_len), .busy(busy[1]),
      .op_valid(op_valid), .op_ready(op_ready[1]),
      .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
      .mac_ce(mac_ce[1]), .mac_reset(mac_reset[1]),
      .mac_a0(ma0[1]), .mac_b0(mb0[1]), .mac_a1(ma1[1]), .mac_b1(mb1[1]),
      .mac_dout(dout[1]), .res_valid(res_valid[1]), .res_ready(res_ready),
      .res_data(rd_b), .res_ovf(res_ovf[1]));

   always #5 clk = ~clk;

   // Dual-MAC: input register stage, then registered a0*b0 + a1*b1.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mac_reset[i]) begin
            for (int j = 0; j < 4; j++) mr[i][j] <= '0;
            dout[i] <= '0;
         end else if (mac_ce[i]) begin
            mr[i][0] <= ma0[i];
            mr[i][1] <= mb0[i];
            mr[i][2] <= ma1[i];
            mr[i][3] <= mb1[i];
            dout[i]  <= OW'(longint'(mr[i][0]) * longint'(mr[i][1]) +
                            longint'(mr[i][2]) * longint'(mr[i][3]));
         end
      end
   end

   always @(negedge clk) begin
      if (op_ready[0]) rdy_cnt++;
      if (mac_ce[0] || mac_ce[1]) ce_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1);
   end

   function automatic quad_t mk(input int a0, input int b0, input int a1, input int b1);
      quad_t q;
      q.a0 = DW'(a0);
      q.b0 = DW'(b0);
      q.a1 = DW'(a1);
      q.b1 = DW'(b1);
      return q;
   endfunction

   function automatic longint wrapw(input longint v, input int w);
      longint m = longint'(1) <<< w;
      longint r = v & (m - 1);
      if (r >= m / 2) r = r - m;
      return r;
   endfunction

   // Dot product with w-bit two's-complement wrap; ovf when any running sum leaves range.
   function automatic void ref_dot(input quad_t q[$], input int w, output longint res, output bit ovf);
      longint acc = 0;
      longint s;
      longint hi = (longint'(1) <<< (w - 1)) - 1;
      longint lo = -(longint'(1) <<< (w - 1));
      ovf = 1'b0;
      foreach (q[i]) begin
         s = acc + longint'(q[i].a0) * longint'(q[i].b0) + longint'(q[i].a1) * longint'(q[i].b1);
         if (s > hi || s < lo) ovf = 1'b1;
         acc = wrapw(s, w);
      end
      res = acc;
   endfunction

   function automatic logic signed [DW-1:0] rnd_op();
      if ($urandom_range(3, 0) == 0) return DW'(-131072);
      return DW'($urandom);
   endfunction

   task automatic do_start(input int len);
      cfg_len = LW'(len);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_quad(input quad_t qd, output bit ok);
      int n = 0;
      op_a0 = qd.a0; op_b0 = qd.b0; op_a1 = qd.a1; op_b1 = qd.b1;
      op_valid = 1'b1;
      while (!op_ready[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = op_ready[0];
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic send_job(input quad_t q[$], input int gap_lo, input int gap_hi, output bit ok);
      bit one;
      ok = 1'b1;
      foreach (q[i]) begin
         repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
         send_quad(q[i], one);
         ok = ok & one;
      end
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (!res_valid[0] && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if ({busy[i], op_ready[i], res_valid[i], res_ovf[i], mac_ce[i], mac_reset[i]} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d]: got %b required 000001", i,
                     {busy[i], op_ready[i], res_valid[i], res_ovf[i], mac_ce[i], mac_reset[i]});
         end
         n_chk++;
         if ({ma0[i], mb0[i], ma1[i], mb1[i]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mac_ops[%0d]: got %h required 0", i, {ma0[i], mb0[i], ma1[i], mb1[i]});
         end
      end
      n_chk++;
      if (rd_a !== '0 || rd_b !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %0d/%0d required 0", rd_a, rd_b);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      quad_t q[$];
      bit ok;
      int n;
      q.push_back(mk(3, 4, -5, 6));
      do_start(1);
      send_job(q, 0, 0, ok);
      wait_result(n);
      n_chk++;
      if (ok !== 1'b1 || n !== 3) begin
         n_fail++;
         $display("FAIL single_latency: got accepted=%0b cycles=%0d required 1/3", ok, n);
      end
      n_chk++;
      if (rd_a !== -18 || rd_b !== -18 || res_ovf[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_data: got %0d/%0d ovf=%0b required -18/-18 ovf=0", rd_a, rd_b, res_ovf[0]);
      end
      release_result();
      n_chk++;
      if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: got valid=%0b busy=%0b required 0/0", res_valid[0], busy[0]);
      end
   endtask

   task automatic test_back_to_back();
      quad_t q[$];
      bit ok;
      int n, r0;
      repeat (4) q.push_back(mk(100, 200, 300, 400));
      r0 = rdy_cnt;
      do_start(4);
      send_job(q, 0, 0, ok);
      n_chk++;
      if (op_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready_drop: got %0b required 0", op_ready[0]);
      end
      wait_result(n);
      n_chk++;
      if (rdy_cnt - r0 !== 4) begin
         n_fail++;
         $display("FAIL b2b_ready_cycles: got %0d required 4", rdy_cnt - r0);
      end
      n_chk++;
      if (ok !== 1'b1 || n !== 3 || rd_a !== 560000 || rd_b !== 560000) begin
         n_fail++;
         $display("FAIL b2b_data: got ok=%0b lat=%0d data=%0d/%0d required 1/3/560000", ok, n, rd_a, rd_b);
      end
      release_result();
   endtask

   task automatic test_gaps_hold();
      quad_t q[$];
      bit ok, stable;
      int n;
      logic signed [AWA-1:0] d;
      q.push_back(mk(-32768, 1, 0, 0));
      q.push_back(mk(1, -32768, 0, 0));
      q.push_back(mk(7, 7, 7, 7));
      do_start(3);
      send_job(q, 2, 2, ok);
      wait_result(n);
      n_chk++;
      if (ok !== 1'b1 || rd_a !== -65438 || rd_b !== -65438) begin
         n_fail++;
         $display("FAIL gaps_data: got ok=%0b data=%0d/%0d required 1/-65438", ok, rd_a, rd_b);
      end
      d = rd_a;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         cfg_len = LW'(3);
         @(negedge clk);
         if (rd_a !== d || busy[0] !== 1'b1 || res_valid[0] !== 1'b1) stable = 1'b0;
      end
      start = 1'b0;
      n_chk++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_stable: got data=%0d busy=%0b valid=%0b required %0d/1/1", rd_a, busy[0], res_valid[0], d);
      end
      release_result();
      n_chk++;
      if (busy[0] !== 1'b0 || res_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: got busy=%0b valid=%0b required 0/0", busy[0], res_valid[0]);
      end
   endtask

   task automatic test_zero_len();
      int c0 = ce_cnt;
      do_start(0);
      n_chk++;
      if (res_valid[0] !== 1'b1 || rd_a !== '0 || rd_b !== '0 || res_ovf[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: got valid=%0b data=%0d/%0d ovf=%0b required 1/0/0/0", res_valid[0], rd_a, rd_b, res_ovf[0]);
      end
      release_result();
      n_chk++;
      if (ce_cnt - c0 !== 0) begin
         n_fail++;
         $display("FAIL zero_len_ce: got %0d ce cycles required 0", ce_cnt - c0);
      end
   endtask

   task automatic test_overflow();
      quad_t q[$];
      bit ok, ea_ovf, eb_ovf;
      int n;
      longint ea, eb;
      repeat (4) q.push_back(mk(-131072, -131072, -131072, -131072));
      ref_dot(q, AWA, ea, ea_ovf);
      ref_dot(q, AWB, eb, eb_ovf);
      do_start(4);
      send_job(q, 0, 1, ok);
      wait_result(n);
      n_chk++;
      if (rd_a !== ea || res_ovf[0] !== ea_ovf) begin
         n_fail++;
         $display("FAIL ovf_wide: got %0d ovf=%0b required %0d ovf=%0b", rd_a, res_ovf[0], ea, ea_ovf);
      end
      n_chk++;
      if (rd_b !== eb || res_ovf[1] !== eb_ovf) begin
         n_fail++;
         $display("FAIL ovf_narrow: got %0d ovf=%0b required %0d ovf=%0b", rd_b, res_ovf[1], eb, eb_ovf);
      end
      release_result();
      q.delete();
      q.push_back(mk(1, 1, 0, 0));
      do_start(1);
      send_job(q, 0, 0, ok);
      wait_result(n);
      n_chk++;
      if (rd_b !== 1 || res_ovf[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %0d ovf=%0b required 1 ovf=0", rd_b, res_ovf[1]);
      end
      release_result();
   endtask

   task automatic test_reset_mid_job();
      quad_t q[$];
      bit ok;
      int n;
      q.push_back(mk(9, 9, 9, 9));
      q.push_back(mk(-5, 3, 2, 1));
      do_start(4);
      send_job(q, 0, 0, ok);
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({busy[0], op_ready[0], res_valid[0], res_ovf[0], mac_ce[0], mac_reset[0]} !== 6'b000001 ||
          rd_a !== '0 || {ma0[0], mb0[0], ma1[0], mb1[0]} !== '0) begin
         n_fail++;
         $display("FAIL midjob_reset: got ctrl=%b data=%0d ops=%h required 000001/0/0",
                  {busy[0], op_ready[0], res_valid[0], res_ovf[0], mac_ce[0], mac_reset[0]},
                  rd_a, {ma0[0], mb0[0], ma1[0], mb1[0]});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      q.delete();
      q.push_back(mk(2, 3, 4, 5));
      do_start(1);
      send_job(q, 0, 0, ok);
      wait_result(n);
      n_chk++;
      if (ok !== 1'b1 || n !== 3 || rd_a !== 26 || rd_b !== 26) begin
         n_fail++;
         $display("FAIL midjob_after: got ok=%0b lat=%0d data=%0d/%0d required 1/3/26", ok, n, rd_a, rd_b);
      end
      release_result();
   endtask

   task automatic test_random();
      for (int j = 0; j < 20; j++) begin
         quad_t q[$];
         bit ok, ea_ovf, eb_ovf;
         int n, len;
         longint ea, eb;
         len = $urandom_range(8, 1);
         for (int k = 0; k < len; k++) q.push_back({rnd_op(), rnd_op(), rnd_op(), rnd_op()});
         ref_dot(q, AWA, ea, ea_ovf);
         ref_dot(q, AWB, eb, eb_ovf);
         do_start(len);
         send_job(q, 0, 2, ok);
         wait_result(n);
         n_chk++;
         if (ok !== 1'b1 || n !== 3) begin
            n_fail++;
            $display("FAIL rnd%0d_latency: got ok=%0b lat=%0d required 1/3", j, ok, n);
         end
         n_chk++;
         if (rd_a !== ea || res_ovf[0] !== ea_ovf) begin
            n_fail++;
            $display("FAIL rnd%0d_wide: got %0d ovf=%0b required %0d ovf=%0b", j, rd_a, res_ovf[0], ea, ea_ovf);
         end
         n_chk++;
         if (rd_b !== eb || res_ovf[1] !== eb_ovf) begin
            n_fail++;
            $display("FAIL rnd%0d_narrow: got %0d ovf=%0b required %0d ovf=%0b", j, rd_b, res_ovf[1], eb, eb_ovf);
         end
         repeat ($urandom_range(3, 0)) @(negedge clk);
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gaps_hold();
      test_zero_len();
      test_overflow();
      test_reset_mid_job();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
